uart_top: RTL and testbench
===========================

Name: uart_top

Overview:
- Full-duplex 8N1 UART with on-chip baud tick generator, transmit FIFO and receive FIFO.
- Host side is a simple write/read strobe interface; line side is one serial output and one serial input.
- Sits between a CPU/bus register shim and the board pins.
- Loopback (tx tied to rx) is the primary bench configuration.

Parameters:
- DBIT, 8, data bits per frame.
- SB_TICK, 16, oversample ticks for the stop bit (16 = 1 stop bit).
- DVSR, 4, clk cycles per oversample tick (bit period = 16*DVSR = 64 clk; frame = 640 clk).
- FIFO_AW, 2, FIFO address width (depth 4) for both TX and RX FIFOs.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- wruart  in  1  one-cycle strobe: push wdata into TX FIFO.
- wdata  in  8  byte to transmit.
- rduart  in  1  one-cycle strobe: pop the head of the RX FIFO.
- rx  in  1  serial input, idle high; only bit 0 is used if the driving net is wider.
- tx  out  1  serial output, idle high.
- txfull  out  1  TX FIFO full.
- rxempty  out  1  RX FIFO empty.
- rdata  out  8  head of RX FIFO (show-ahead; valid while rxempty=0).

Behaviour:
- Reset (async, rstn=0):
  - tx=1, txfull=0, rxempty=1, rdata=0.
  - FIFOs emptied; both FSMs go to idle; tick counter cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high.
- Baud generator: mod-DVSR counter; tick pulses high for 1 clk when the counter reaches DVSR-1.
- Both FIFOs:
  - Write when wr && !full; read when rd && !empty.
  - Simultaneous rd and wr: when full, both are performed; when empty, write only.
  - Pointers wrap mod depth; full/empty flags are registered.
  - Write to a full FIFO and read from an empty FIFO are ignored with no state change.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: tx=1. When TX FIFO is non-empty, latch the head byte, pop it the same cycle, go to START.
  - START: tx=0 for 16 ticks.
  - DATA: DBIT bits LSB first, 16 ticks each.
  - STOP: tx=1 for SB_TICK ticks, then back to IDLE.
  - Back-to-back FIFO bytes produce contiguous frames with no extra idle.
  - Latency wruart to tx falling edge: ≤ DVSR+2 clk.
  - txfull asserts after 5 writes while idle: the first byte is popped into the shifter.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - IDLE: wait for a low level, go to START.
  - START: at tick 7 resample; if still low, restart the count and go to DATA, else return to IDLE (glitch reject).
  - DATA: sample at tick 15 of each bit, shift LSB first, DBIT bits.
  - STOP: wait SB_TICK ticks, then check the stop level.
    - Stop sample high: push the byte into the RX FIFO (1-clk pulse).
    - Stop sample low (framing error): discard the byte.
  - Byte arriving while the RX FIFO is full is dropped; the FIFO is unchanged.
- rdata updates on the clk after a pop or after a push into an empty FIFO.
- Loopback end-to-end: wruart to rxempty=0 in ≤ 700 clk at default parameters.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined:
  - TX inserts an even-parity bit (16 ticks) between the last data bit and the stop bit.
  - RX samples the parity bit and discards any byte whose parity mismatches.
  - Frame becomes 11 bits (704 clk at defaults).
- When undefined: plain 8N1 as above; no parity logic synthesized.

Test Plan:
- Loopback, write 0x55 once, wait 1000 clk → rxempty=0 and rdata=0x55; pulse rduart → rxempty=1 next clk.
- Loopback, 100 random bytes, each followed by 1000 clk then a read → every rdata equals the byte written; no drops.
- TX FIFO fill: 6 back-to-back writes 0x01..0x06 with no reads → txfull=1 after write 5, write 6 ignored; rx side receives 0x01..0x05 in order (RX FIFO full after 4, 0x05 dropped).
- rx glitch: drive rx low for 2*DVSR clk then high → no byte pushed, rxempty stays 1.
- Reset mid-frame: assert rstn=0 at clk 200 of a frame → tx=1, txfull=0, rxempty=1, rdata=0 immediately; the next write transmits correctly.
- Read while empty: pulse rduart with rxempty=1 → no change, rdata=0.

Source files
------------

// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART with baud tick generator and 4-deep TX/RX FIFOs.
// Optional build macro UART_PARITY_EN adds an even-parity bit to every frame.

module uart_fifo #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_i,
   input  logic          rd_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, wp_nx, rp_nx;
   logic          full_q, full_d, empty_q, empty_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          wr_en, rd_en;

   always_comb begin
      wr_en   = wr_i && (!full_q || rd_i);
      rd_en   = rd_i && !empty_q;
      wp_nx   = wp_q + 1'b1;
      rp_nx   = rp_q + 1'b1;
      wp_d    = wr_en ? wp_nx : wp_q;
      rp_d    = rd_en ? rp_nx : rp_q;
      full_d  = full_q;
      empty_d = empty_q;
      rdata_d = rdata_q;
      if (wr_en && !rd_en) begin
         empty_d = 1'b0;
         full_d  = (wp_nx == rp_q);
      end else if (rd_en && !wr_en) begin
         full_d  = 1'b0;
         empty_d = (rp_nx == wp_q);
      end
      // rdata is a registered show-ahead copy of the head entry
      if (wr_en && empty_q) begin
         rdata_d = wdata_i;
      end else if (rd_en) begin
         if (wr_en && (rp_nx == wp_q)) rdata_d = wdata_i;
         else if (rp_nx != wp_q)       rdata_d = mem[rp_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wp_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp_q    <= '0;
         rp_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         rdata_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;
endmodule

module uart_top #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 4,
   parameter int FIFO_AW = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            wruart,
   input  logic [DBIT-1:0] wdata,
   input  logic            rduart,
   input  logic            rx,
   output logic            tx,
   output logic            txfull,
   output logic            rxempty,
   output logic [DBIT-1:0] rdata
);
   localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PAR,
`endif
      S_STOP
   } state_t;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;

   state_t          tx_st_q, tx_st_d;
   logic [SW-1:0]   tx_s_q, tx_s_d;
   logic [NW-1:0]   tx_n_q, tx_n_d;
   logic [DBIT-1:0] tx_b_q, tx_b_d, tx_head;
   logic            tx_q, tx_d, tx_pop, tx_load, tx_empty;

   state_t          rx_st_q, rx_st_d;
   logic [SW-1:0]   rx_s_q, rx_s_d;
   logic [NW-1:0]   rx_n_q, rx_n_d;
   logic [DBIT-1:0] rx_b_q, rx_b_d;
   logic            rx_m_q, rx_sync_q, rx_push, rx_full;
`ifdef UART_PARITY_EN
   logic            tx_p_q, tx_p_d, rx_perr_q, rx_perr_d;
`endif

   always_comb begin
      tick  = (cnt_q == CW'(DVSR - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      tx_st_d = tx_st_q;
      tx_s_d  = tx_s_q;
      tx_n_d  = tx_n_q;
      tx_b_d  = tx_b_q;
      tx_d    = 1'b1;
      tx_pop  = 1'b0;
      tx_load = 1'b0;
`ifdef UART_PARITY_EN
      tx_p_d  = tx_p_q;
`endif
      case (tx_st_q)
         S_IDLE: tx_load = !tx_empty;
         S_START: begin
            tx_d = 1'b0;
            if (tick) begin
               if (tx_s_q == SW'(15)) begin
                  tx_s_d  = '0;
                  tx_n_d  = '0;
                  tx_st_d = S_DATA;
               end else tx_s_d = tx_s_q + 1'b1;
            end
         end
         S_DATA: begin
            tx_d = tx_b_q[0];
            if (tick) begin
               if (tx_s_q == SW'(15)) begin
                  tx_s_d = '0;
                  tx_b_d = tx_b_q >> 1;
                  if (tx_n_q == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                     tx_st_d = S_PAR;
`else
                     tx_st_d = S_STOP;
`endif
                  end else tx_n_d = tx_n_q + 1'b1;
               end else tx_s_d = tx_s_q + 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         S_PAR: begin
            tx_d = tx_p_q;
            if (tick) begin
               if (tx_s_q == SW'(15)) begin
                  tx_s_d  = '0;
                  tx_st_d = S_STOP;
               end else tx_s_d = tx_s_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (tx_s_q == SW'(SB_TICK - 1)) begin
                  tx_st_d = S_IDLE;
                  tx_load = !tx_empty;
               end else tx_s_d = tx_s_q + 1'b1;
            end
         end
         default: tx_st_d = S_IDLE;
      endcase
      // Loading straight from STOP keeps queued frames contiguous
      if (tx_load) begin
         tx_pop  = 1'b1;
         tx_b_d  = tx_head;
         tx_s_d  = '0;
         tx_st_d = S_START;
`ifdef UART_PARITY_EN
         tx_p_d  = ^tx_head;
`endif
      end
   end

   always_comb begin
      rx_st_d = rx_st_q;
      rx_s_d  = rx_s_q;
      rx_n_d  = rx_n_q;
      rx_b_d  = rx_b_q;
      rx_push = 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_d = rx_perr_q;
`endif
      case (rx_st_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               rx_s_d  = '0;
               rx_st_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s_q == SW'(7)) begin
                  rx_s_d  = '0;
                  rx_n_d  = '0;
                  rx_st_d = rx_sync_q ? S_IDLE : S_DATA;
               end else rx_s_d = rx_s_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (rx_s_q == SW'(15)) begin
                  rx_s_d = '0;
                  rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                  if (rx_n_q == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                     rx_st_d = S_PAR;
`else
                     rx_st_d = S_STOP;
`endif
                  end else rx_n_d = rx_n_q + 1'b1;
               end else rx_s_d = rx_s_q + 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         S_PAR: begin
            if (tick) begin
               if (rx_s_q == SW'(15)) begin
                  rx_s_d    = '0;
                  rx_perr_d = rx_sync_q ^ (^rx_b_q);
                  rx_st_d   = S_STOP;
               end else rx_s_d = rx_s_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rx_s_q == SW'(SB_TICK - 1)) begin
                  rx_st_d = S_IDLE;
`ifdef UART_PARITY_EN
                  rx_push = rx_sync_q && !rx_full && !rx_perr_q;
`else
                  rx_push = rx_sync_q && !rx_full;
`endif
               end else rx_s_d = rx_s_q + 1'b1;
            end
         end
         default: rx_st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         tx_st_q   <= S_IDLE;
         tx_s_q    <= '0;
         tx_n_q    <= '0;
         tx_b_q    <= '0;
         tx_q      <= 1'b1;
         rx_st_q   <= S_IDLE;
         rx_s_q    <= '0;
         rx_n_q    <= '0;
         rx_b_q    <= '0;
         rx_m_q    <= 1'b1;
         rx_sync_q <= 1'b1;
`ifdef UART_PARITY_EN
         tx_p_q    <= 1'b0;
         rx_perr_q <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         tx_st_q   <= tx_st_d;
         tx_s_q    <= tx_s_d;
         tx_n_q    <= tx_n_d;
         tx_b_q    <= tx_b_d;
         tx_q      <= tx_d;
         rx_st_q   <= rx_st_d;
         rx_s_q    <= rx_s_d;
         rx_n_q    <= rx_n_d;
         rx_b_q    <= rx_b_d;
         rx_m_q    <= rx;
         rx_sync_q <= rx_m_q;
`ifdef UART_PARITY_EN
         tx_p_q    <= tx_p_d;
         rx_perr_q <= rx_perr_d;
`endif
      end
   end

   assign tx = tx_q;

   uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .rstn(rstn), .wr_i(wruart), .rd_i(tx_pop), .wdata_i(wdata),
      .rdata_o(tx_head), .full_o(txfull), .empty_o(tx_empty)
   );

   uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .rstn(rstn), .wr_i(rx_push), .rd_i(rduart), .wdata_i(rx_b_q),
      .rdata_o(rdata), .full_o(rx_full), .empty_o(rxempty)
   );
endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: loopback traffic, FIFO limits, bit-level line
// checks, glitch and framing rejection, and asynchronous reset mid-frame.
`timescale 1ns/1ps
module tb_uart_top;
   localparam int DVSR = 4;
   localparam int BIT  = 64;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       wruart = 1'b0;
   logic       rduart = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       loop_en = 1'b1;
   logic       rx_drv = 1'b1;
   logic       rx, tx, txfull, rxempty;
   logic [7:0] rdata;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;
   assign rx = loop_en ? tx : rx_drv;

   uart_top dut (
      .clk(clk), .rstn(rstn), .wruart(wruart), .wdata(wdata), .rduart(rduart),
      .rx(rx), .tx(tx), .txfull(txfull), .rxempty(rxempty), .rdata(rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wdata  = b;
      wruart = 1'b1;
      @(negedge clk);
      wruart = 1'b0;
   endtask

   task automatic read_byte();
      rduart = 1'b1;
      @(negedge clk);
      rduart = 1'b0;
   endtask

   task automatic wait_rx(input int budget, output int lat);
      lat = 0;
      while (rxempty && lat < budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Compare the RX head with the scoreboard, then pop it from the DUT
   task automatic pop_check(input string tag);
      logic [31:0] exp;
      if (sb.size() > 0) exp = {24'h0, sb.pop_front()};
      else               exp = 32'h1ff;
      check({tag, "_rdata"}, {24'h0, rdata}, exp);
      read_byte();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      rx_drv = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx_drv = b[k];
         repeat (BIT) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rx_drv = ^b;
      repeat (BIT) @(negedge clk);
`endif
      rx_drv = stop_ok;
      repeat (stop_ok ? BIT : 48) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         t0;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_txfull", txfull, 0);
      check("rst_rxempty", rxempty, 1);
      check("rst_rdata", rdata, 0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      read_byte();
      check("rd_empty_rxempty", rxempty, 1);
      check("rd_empty_rdata", rdata, 0);

      // 0x55: latency, bit-level line shape, then loopback delivery
      b = 8'h55;
      sb.push_back(b);
      t0 = int'($time / 10);
      write_byte(b);
      lat = 1;
      while (tx && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("tx_latency_ok", lat <= DVSR + 2, 1);
      repeat (BIT / 2) @(negedge clk);
      check("line_start", tx, 0);
      for (int k = 0; k < 8; k++) begin
         repeat (BIT) @(negedge clk);
         check($sformatf("line_bit%0d", k), tx, b[k]);
      end
`ifdef UART_PARITY_EN
      repeat (BIT) @(negedge clk);
      check("line_parity", tx, ^b);
`endif
      repeat (BIT) @(negedge clk);
      check("line_stop", tx, 1);
      wait_rx(1000, lat);
      check("e2e_le_700", (int'($time / 10) - t0) <= 700, 1);
      check("b55_arrive_rxempty", rxempty, 0);
      pop_check("b55");
      check("b55_rxempty_after_pop", rxempty, 1);

      for (int i = 0; i < 100; i++) begin
         b = 8'($urandom_range(0, 255));
         sb.push_back(b);
         write_byte(b);
         wait_rx(1000, lat);
         check($sformatf("rand%0d_arrive", i), rxempty, 0);
         pop_check($sformatf("rand%0d", i));
      end
      check("rand_no_extra", rxempty, 1);

      // TX FIFO fill: shifter takes byte 1, FIFO holds 2..5, byte 6 refused
      repeat (100) @(negedge clk);
      for (int i = 1; i <= 6; i++) begin
         if (i == 5) check("fill_txfull_after4", txfull, 0);
         if (i == 6) check("fill_txfull_after5", txfull, 1);
         if (i <= 4) sb.push_back(8'(i));
         wdata  = 8'(i);
         wruart = 1'b1;
         @(negedge clk);
      end
      wruart = 1'b0;
      check("fill_txfull_after6", txfull, 1);
      repeat (3600) @(negedge clk);
      check("fill_txfull_drained", txfull, 0);
      check("fill_tx_idle", tx, 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("fill%0d_avail", i), rxempty, 0);
         pop_check($sformatf("fill%0d", i));
      end
      check("fill_b5_dropped", rxempty, 1);

      // Receiver driven directly: glitch, good frame, framing error
      loop_en = 1'b0;
      rx_drv  = 1'b0;
      repeat (2 * DVSR) @(negedge clk);
      rx_drv = 1'b1;
      repeat (1000) @(negedge clk);
      check("glitch_rxempty", rxempty, 1);

      sb.push_back(8'hC6);
      send_frame(8'hC6, 1'b1);
      wait_rx(200, lat);
      check("bang_c6_arrive", rxempty, 0);
      pop_check("bang_c6");
      send_frame(8'h3A, 1'b0);
      repeat (400) @(negedge clk);
      check("framing_discard", rxempty, 1);
      loop_en = 1'b1;
      repeat (10) @(negedge clk);

      // Reset mid-frame with a byte sitting in the RX FIFO
      write_byte(8'h3C);
      wait_rx(1000, lat);
      check("pre_rst_rdata", rdata, 8'h3C);
      write_byte(8'hA3);
      repeat (200) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_txfull", txfull, 0);
      check("midrst_rxempty", rxempty, 1);
      check("midrst_rdata", rdata, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      sb.push_back(8'h96);
      write_byte(8'h96);
      wait_rx(1000, lat);
      check("post_rst_arrive", rxempty, 0);
      pop_check("post_rst");
      check("post_rst_rxempty", rxempty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
